// File: rtl/pc_pkg.sv
// Shared definitions for the CPU program counter slice.
//
// Contents:
//   PC_WIDTH        address width in bits
//   PC_RESET_VALUE  value the program counter takes while reset_n is low
//   pc_addr_t       instruction address type
package pc_pkg;

  localparam int PC_WIDTH = 8;
  localparam logic [PC_WIDTH-1:0] PC_RESET_VALUE = 8'h00;

  typedef logic [PC_WIDTH-1:0] pc_addr_t;

endpackage

// File: rtl/program_counter_if.sv
// Control-unit <-> program-counter bus.
//
// Signals:
//   load        load request, takes load_value on the next rising edge
//   enable      increment request
//   load_value  absolute jump target
//   pc_out      current program counter
//   wrap        increment-wrap flag (present only with PC_WRAP_FLAG_EN)
//
// Modports:
//   master  control unit side (drives strobes and target, reads pc_out)
//   slave   program counter side
//
// Build option: PC_WRAP_FLAG_EN adds the wrap signal to both modports.
interface program_counter_if
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
);

  logic             load;
  logic             enable;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] pc_out;
`ifdef PC_WRAP_FLAG_EN
  logic             wrap;

  modport master (output load, enable, load_value, input pc_out, wrap);
  modport slave  (input load, enable, load_value, output pc_out, wrap);
`else
  modport master (output load, enable, load_value, input pc_out);
  modport slave  (input load, enable, load_value, output pc_out);
`endif

endinterface

// File: rtl/pc_incrementer.sv
// Combinational +1 for the program counter, built as a ripple chain of
// half adders with the carry-in of bit 0 tied high.
//
// Ports:
//   a          input   WIDTH  operand
//   sum        output  WIDTH  a + 1 (modulo 2^WIDTH)
//   carry_out  output  1      carry out of the top bit, i.e. a was all ones
module pc_incrementer
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  // The chain carry is a procedural variable so each stage reads the
  // previous stage's carry without forming a self-referencing vector.
  always_comb begin
    logic w_c;
    w_c = 1'b1;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ w_c;
      w_c    = a[i] & w_c;
    end
    carry_out = w_c;
  end

endmodule

// File: rtl/program_counter.sv
// CPU program counter: holds the current instruction address, increments
// by one per enabled clock and accepts an absolute load for jumps.
// Priority per rising edge: load > enable > hold.
//
// Ports:
//   clk      input   single clock, rising-edge
//   reset_n  input   asynchronous active-low reset
//   bus      program_counter_if.slave
//              load, enable, load_value in; pc_out (and wrap) out
//
// Build option: PC_WRAP_FLAG_EN adds a registered wrap flag that is high
// for one cycle after an increment from all ones to zero.
module program_counter
  import pc_pkg::*;
#(
  parameter int               WIDTH       = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VALUE)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  program_counter_if.slave      bus
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_pc_next;
  logic             w_carry;

  pc_incrementer #(
    .WIDTH (WIDTH)
  ) u_inc (
    .a         (r_pc),
    .sum       (w_pc_inc),
    .carry_out (w_carry)
  );

  // 3:1 next-value mux: load, increment, hold.
  always_comb begin
    w_pc_next = r_pc;
    if (bus.load) begin
      w_pc_next = bus.load_value;
    end else if (bus.enable) begin
      w_pc_next = w_pc_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= RESET_VALUE;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign bus.pc_out = r_pc;

`ifdef PC_WRAP_FLAG_EN
  logic r_wrap;

  // Set only by an increment that carries out of the top bit; a load or
  // a hold cycle clears it, so it is a single-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= !bus.load && bus.enable && w_carry;
    end
  end

  assign bus.wrap = r_wrap;
`else
  // Without the flag the counter wraps silently; the carry is not needed.
  logic w_unused_carry;
  assign w_unused_carry = w_carry;
`endif

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;
  import pc_pkg::*;

  localparam int MOD = 2 ** PC_WIDTH;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  program_counter_if #(.WIDTH(PC_WIDTH)) bus ();

  program_counter #(
    .WIDTH       (PC_WIDTH),
    .RESET_VALUE (PC_RESET_VALUE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the address as a plain integer and the wrap flag.
  int m_pc   = 0;
  bit m_wrap = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(string tag);
    chk({tag, ".pc"}, 32'(bus.pc_out), 32'(m_pc));
`ifdef PC_WRAP_FLAG_EN
    chk({tag, ".wrap"}, 32'(bus.wrap), 32'(m_wrap));
`endif
  endtask

  // Called at a falling edge; reset takes effect in the model at once.
  task automatic drive(bit r, bit ld, bit en, logic [PC_WIDTH-1:0] lv);
    bus.load       = ld;
    bus.enable     = en;
    bus.load_value = lv;
    reset_n        = r;
    if (!r) begin
      m_pc   = int'(PC_RESET_VALUE);
      m_wrap = 1'b0;
    end
  endtask

  // One rising edge, model update from the inputs it sampled, then check
  // on the following falling edge.
  task automatic cycle(string tag);
    @(posedge clk);
    if (reset_n) begin
      if (bus.load) begin
        m_pc   = int'(bus.load_value);
        m_wrap = 1'b0;
      end else if (bus.enable) begin
        m_wrap = (m_pc == MOD - 1);
        m_pc   = (m_pc + 1) % MOD;
      end else begin
        m_wrap = 1'b0;
      end
    end
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    pc_addr_t lv;
    bit       ld, en, r;

    // Reset held with both strobes asserted.
    drive(1'b0, 1'b1, 1'b1, 8'h5A);
    #1 check_state("reset_async");
    cycle("reset_e1");
    cycle("reset_e2");
    chk("reset_val", 32'(bus.pc_out), 32'h00);

    drive(1'b1, 1'b0, 1'b0, 8'h00);
    cycle("idle1");
    cycle("idle2");
    chk("idle_val", 32'(bus.pc_out), 32'h00);

    // Increment three times then hold.
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    cycle("inc1");
    cycle("inc2");
    cycle("inc3");
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    cycle("inc_hold");
    chk("inc_val", 32'(bus.pc_out), 32'h03);

    // Load then hold.
    drive(1'b1, 1'b1, 1'b0, 8'h0A);
    cycle("load");
    drive(1'b1, 1'b0, 1'b0, 8'hC3);
    cycle("load_hold");
    chk("load_val", 32'(bus.pc_out), 32'h0A);

    // Load wins over enable.
    drive(1'b1, 1'b1, 1'b1, 8'h55);
    cycle("prio");
    chk("prio_val", 32'(bus.pc_out), 32'h55);

    // Wrap through all ones.
    drive(1'b1, 1'b1, 1'b0, 8'hFE);
    cycle("wrap_load");
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    cycle("wrap_ff");
    chk("wrap_ff_val", 32'(bus.pc_out), 32'hFF);
    cycle("wrap_00");
    chk("wrap_00_val", 32'(bus.pc_out), 32'h00);
`ifdef PC_WRAP_FLAG_EN
    chk("wrap_pulse", 32'(bus.wrap), 32'h1);
`endif
    cycle("wrap_01");
    chk("wrap_01_val", 32'(bus.pc_out), 32'h01);

    // Load of all ones directly, then increment from it.
    drive(1'b1, 1'b1, 1'b0, 8'hFF);
    cycle("ldff");
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    cycle("ldff_inc");

    // Asynchronous reset between edges.
    drive(1'b1, 1'b1, 1'b0, 8'h3C);
    cycle("pre_async");
    chk("pre_async_val", 32'(bus.pc_out), 32'h3C);
    drive(1'b0, 1'b1, 1'b1, 8'h77);
    #1 chk("async_rst", 32'(bus.pc_out), 32'h00);
    cycle("async_hold");
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    cycle("async_release");

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      ld = ($urandom_range(0, 3) == 0);
      en = ($urandom_range(0, 1) == 1);
      r  = ($urandom_range(0, 31) != 0);
      lv = pc_addr_t'($urandom);
      if ($urandom_range(0, 7) == 0) lv = 8'hFF;
      drive(r, ld, en, lv);
      if (!r) begin
        #1 chk("rnd_async", 32'(bus.pc_out), 32'(PC_RESET_VALUE));
      end
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
